// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the MIPS-subset datapath: sequences fetch, decode, execute,
// memory and writeback, with stall handshakes to the instruction and data memories.
module multicycle_control_unit #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned STATE_W = 3
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic [5:0]         opcode,
    input  logic [5:0]         rFunc,
    input  logic               zeroRes,
    input  logic               imemReady,
    input  logic               dmemReady,
    output logic               imemReq,
    output logic               irWriteEn,
    output logic               dmemReq,
    output logic               memWriteEn,
    output logic               pcWriteEn,
    output logic [1:0]         jumpOp,
    output logic [1:0]         extendOp,
    output logic               regWriteEn,
    output logic [1:0]         aluOp,
    output logic               writeReg,
    output logic               srcAlu,
    output logic [1:0]         srcReg,
    output logic               illegalInstr,
    output logic [CNT_W-1:0]   retired,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4
    } state_e;

    typedef enum logic [3:0] {
        ClsNone, ClsAddu, ClsOr, ClsAddiu, ClsLui, ClsLw, ClsSw, ClsBeq, ClsJ
    } cls_e;

    state_e           state_q, state_d;
    cls_e             cls_q, dec_cls;
    logic [CNT_W-1:0] retired_q;
    logic             retire;

    logic       imem_req, ir_we, dmem_req, mem_we, pc_we, reg_we, wr_sel, alu_src, illegal;
    logic [1:0] jump_op, ext_op, alu_op, reg_src;

    always_comb begin
        dec_cls = ClsNone;
        case (opcode)
            6'b000000: begin
                case (rFunc)
                    6'b100000: dec_cls = ClsAddu;
                    6'b100101: dec_cls = ClsOr;
                    default:   dec_cls = ClsNone;
                endcase
            end
            6'b001001: dec_cls = ClsAddiu;
            6'b001111: dec_cls = ClsLui;
            6'b100011: dec_cls = ClsLw;
            6'b101011: dec_cls = ClsSw;
            6'b000100: dec_cls = ClsBeq;
            6'b000010: dec_cls = ClsJ;
            default:   dec_cls = ClsNone;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        retire   = 1'b0;
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        mem_we   = 1'b0;
        pc_we    = 1'b0;
        reg_we   = 1'b0;
        illegal  = 1'b0;
        jump_op  = 2'b00;
        unique case (state_q)
            StFetch: begin
                imem_req = 1'b1;
                if (imemReady) begin
                    ir_we   = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (dec_cls == ClsNone) begin
                    illegal = 1'b1;
                    pc_we   = 1'b1;
                    jump_op = 2'b01;
                    state_d = StFetch;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                case (cls_q)
                    ClsAddu, ClsOr, ClsAddiu, ClsLui: state_d = StWb;
                    ClsLw, ClsSw:                     state_d = StMem;
                    ClsBeq: begin
                        pc_we   = 1'b1;
                        jump_op = zeroRes ? 2'b11 : 2'b01;
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                    ClsJ: begin
                        pc_we   = 1'b1;
                        jump_op = 2'b10;
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                    default: state_d = StFetch;
                endcase
            end
            StMem: begin
                dmem_req = 1'b1;
                mem_we   = (cls_q == ClsSw);
                if (dmemReady) begin
                    if (cls_q == ClsSw) begin
                        pc_we   = 1'b1;
                        jump_op = 2'b01;
                        retire  = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                reg_we  = 1'b1;
                pc_we   = 1'b1;
                jump_op = 2'b01;
                retire  = 1'b1;
                state_d = StFetch;
            end
            default: state_d = StFetch;
        endcase
    end

    // Datapath selects depend only on the latched class and stay put from EXEC to retirement.
    always_comb begin
        ext_op  = 2'b00;
        alu_op  = 2'b00;
        alu_src = 1'b0;
        wr_sel  = 1'b0;
        reg_src = 2'b00;
        if (state_q == StExec || state_q == StMem || state_q == StWb) begin
            case (cls_q)
                ClsAddu:  begin alu_op = 2'b01; wr_sel = 1'b1; reg_src = 2'b10; end
                ClsOr:    begin alu_op = 2'b11; wr_sel = 1'b1; reg_src = 2'b10; end
                ClsAddiu: begin ext_op = 2'b10; alu_src = 1'b1; alu_op = 2'b01; reg_src = 2'b10; end
                ClsLui:   begin ext_op = 2'b01; reg_src = 2'b01; end
                ClsLw:    begin ext_op = 2'b11; alu_src = 1'b1; alu_op = 2'b01; reg_src = 2'b11; end
                ClsSw:    begin ext_op = 2'b11; alu_src = 1'b1; alu_op = 2'b01; end
                ClsBeq:   alu_op = 2'b10;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q   <= StFetch;
            cls_q     <= ClsNone;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) cls_q <= dec_cls;
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    // Reset gates everything combinationally so FETCH's request is not seen while held in reset.
    assign imemReq      = rstN & imem_req;
    assign irWriteEn    = rstN & ir_we;
    assign dmemReq      = rstN & dmem_req;
    assign memWriteEn   = rstN & mem_we;
    assign pcWriteEn    = rstN & pc_we;
    assign regWriteEn   = rstN & reg_we;
    assign writeReg     = rstN & wr_sel;
    assign srcAlu       = rstN & alu_src;
    assign illegalInstr = rstN & illegal;
    assign jumpOp       = rstN ? jump_op : 2'b00;
    assign extendOp     = rstN ? ext_op : 2'b00;
    assign aluOp        = rstN ? alu_op : 2'b00;
    assign srcReg       = rstN ? reg_src : 2'b00;
    assign retired      = rstN ? retired_q : '0;
    assign state        = rstN ? STATE_W'(state_q) : '0;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: steps each instruction class cycle by cycle and
// compares state plus every control output against hand-computed vectors.
module tb_multicycle_control_unit;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic [5:0]  opcode = '0;
    logic [5:0]  rFunc = '0;
    logic        zeroRes = 1'b0;
    logic        imemReady = 1'b0;
    logic        dmemReady = 1'b0;
    logic        imemReq, irWriteEn, dmemReq, memWriteEn, pcWriteEn, regWriteEn;
    logic        writeReg, srcAlu, illegalInstr;
    logic [1:0]  jumpOp, extendOp, aluOp, srcReg;
    logic [31:0] retired;
    logic [2:0]  state;
    logic [16:0] ctl;

    int checks = 0;
    int failures = 0;

    multicycle_control_unit #(.CNT_W(32), .STATE_W(3)) dut (
        .clk(clk), .rstN(rstN), .opcode(opcode), .rFunc(rFunc), .zeroRes(zeroRes),
        .imemReady(imemReady), .dmemReady(dmemReady), .imemReq(imemReq),
        .irWriteEn(irWriteEn), .dmemReq(dmemReq), .memWriteEn(memWriteEn),
        .pcWriteEn(pcWriteEn), .jumpOp(jumpOp), .extendOp(extendOp),
        .regWriteEn(regWriteEn), .aluOp(aluOp), .writeReg(writeReg), .srcAlu(srcAlu),
        .srcReg(srcReg), .illegalInstr(illegalInstr), .retired(retired), .state(state)
    );

    always #5 clk = ~clk;

    // Field order: imq irw dmq mwe pcw jop ext rwe alu wr sa sr ill
    assign ctl = {imemReq, irWriteEn, dmemReq, memWriteEn, pcWriteEn, jumpOp, extendOp,
                  regWriteEn, aluOp, writeReg, srcAlu, srcReg, illegalInstr};

    localparam logic [16:0] C_ZERO   = 17'b0_0_0_0_0_00_00_0_00_0_0_00_0;
    localparam logic [16:0] C_FETCH  = 17'b1_1_0_0_0_00_00_0_00_0_0_00_0;
    localparam logic [16:0] C_FSTALL = 17'b1_0_0_0_0_00_00_0_00_0_0_00_0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [2:0] st, input logic [16:0] c);
        #1;
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".ctl"}, 32'(ctl), 32'(c));
        @(posedge clk);
        #2;
    endtask

    initial begin
        #3;
        chk("rst.ctl", 32'(ctl), 32'(C_ZERO));
        chk("rst.state", 32'(state), 32'd0);
        chk("rst.retired", retired, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        chk("rst_hold.ctl", 32'(ctl), 32'(C_ZERO));
        rstN = 1'b1;

        // ADDIU, one fetch stall first
        opcode = 6'b001001;
        step("addiu.fstall", 3'd0, C_FSTALL);
        imemReady = 1'b1;
        step("addiu.F", 3'd0, C_FETCH);
        step("addiu.D", 3'd1, C_ZERO);
        step("addiu.E", 3'd2, 17'b0_0_0_0_0_00_10_0_01_0_1_10_0);
        step("addiu.W", 3'd4, 17'b0_0_0_0_1_01_10_1_01_0_1_10_0);
        chk("addiu.retired", retired, 32'd1);

        // LW, three data stalls; opcode/imemReady changes after decode must be ignored
        opcode = 6'b100011;
        step("lw.F", 3'd0, C_FETCH);
        step("lw.D", 3'd1, C_ZERO);
        opcode = 6'b111111;
        step("lw.E", 3'd2, 17'b0_0_0_0_0_00_11_0_01_0_1_11_0);
        step("lw.M0", 3'd3, 17'b0_0_1_0_0_00_11_0_01_0_1_11_0);
        step("lw.M1", 3'd3, 17'b0_0_1_0_0_00_11_0_01_0_1_11_0);
        step("lw.M2", 3'd3, 17'b0_0_1_0_0_00_11_0_01_0_1_11_0);
        dmemReady = 1'b1;
        step("lw.M3", 3'd3, 17'b0_0_1_0_0_00_11_0_01_0_1_11_0);
        step("lw.W", 3'd4, 17'b0_0_0_0_1_01_11_1_01_0_1_11_0);
        chk("lw.retired", retired, 32'd2);

        // SW, data memory ready at once
        opcode = 6'b101011;
        step("sw.F", 3'd0, C_FETCH);
        step("sw.D", 3'd1, C_ZERO);
        step("sw.E", 3'd2, 17'b0_0_0_0_0_00_11_0_01_0_1_00_0);
        step("sw.M", 3'd3, 17'b0_0_1_1_1_01_11_0_01_0_1_00_0);
        chk("sw.retired", retired, 32'd3);

        // BEQ taken then not taken
        opcode = 6'b000100;
        zeroRes = 1'b1;
        step("beq1.F", 3'd0, C_FETCH);
        step("beq1.D", 3'd1, C_ZERO);
        step("beq1.E", 3'd2, 17'b0_0_0_0_1_11_00_0_10_0_0_00_0);
        zeroRes = 1'b0;
        step("beq0.F", 3'd0, C_FETCH);
        step("beq0.D", 3'd1, C_ZERO);
        step("beq0.E", 3'd2, 17'b0_0_0_0_1_01_00_0_10_0_0_00_0);
        chk("beq.retired", retired, 32'd5);

        // J
        opcode = 6'b000010;
        step("j.F", 3'd0, C_FETCH);
        step("j.D", 3'd1, C_ZERO);
        step("j.E", 3'd2, 17'b0_0_0_0_1_10_00_0_00_0_0_00_0);
        chk("j.retired", retired, 32'd6);

        // ADDU
        opcode = 6'b000000;
        rFunc = 6'b100000;
        step("addu.F", 3'd0, C_FETCH);
        step("addu.D", 3'd1, C_ZERO);
        step("addu.E", 3'd2, 17'b0_0_0_0_0_00_00_0_01_1_0_10_0);
        step("addu.W", 3'd4, 17'b0_0_0_0_1_01_00_1_01_1_0_10_0);

        // OR
        rFunc = 6'b100101;
        step("or.F", 3'd0, C_FETCH);
        step("or.D", 3'd1, C_ZERO);
        step("or.E", 3'd2, 17'b0_0_0_0_0_00_00_0_11_1_0_10_0);
        step("or.W", 3'd4, 17'b0_0_0_0_1_01_00_1_11_1_0_10_0);

        // LUI
        opcode = 6'b001111;
        step("lui.F", 3'd0, C_FETCH);
        step("lui.D", 3'd1, C_ZERO);
        step("lui.E", 3'd2, 17'b0_0_0_0_0_00_01_0_00_0_0_01_0);
        step("lui.W", 3'd4, 17'b0_0_0_0_1_01_01_1_00_0_0_01_0);
        chk("lui.retired", retired, 32'd9);

        // Unsupported R-type func
        opcode = 6'b000000;
        rFunc = 6'b101010;
        step("ill.F", 3'd0, C_FETCH);
        step("ill.D", 3'd1, 17'b0_0_0_0_1_01_00_0_00_0_0_00_1);
        chk("ill.state", 32'(state), 32'd0);
        chk("ill.retired", retired, 32'd9);

        // LW aborted by reset during a data stall
        opcode = 6'b100011;
        dmemReady = 1'b0;
        step("lwa.F", 3'd0, C_FETCH);
        step("lwa.D", 3'd1, C_ZERO);
        step("lwa.E", 3'd2, 17'b0_0_0_0_0_00_11_0_01_0_1_11_0);
        #1;
        chk("lwa.M.ctl", 32'(ctl), 32'(17'b0_0_1_0_0_00_11_0_01_0_1_11_0));
        rstN = 1'b0;
        #1;
        chk("lwa.rst.ctl", 32'(ctl), 32'(C_ZERO));
        chk("lwa.rst.state", 32'(state), 32'd0);
        chk("lwa.rst.retired", retired, 32'd0);
        @(posedge clk);
        #2;
        rstN = 1'b1;
        imemReady = 1'b0;
        dmemReady = 1'b1;
        step("post.0", 3'd0, C_FSTALL);
        step("post.1", 3'd0, C_FSTALL);
        chk("post.retired", retired, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle sequencer for the fever MIPS-subset datapath: LUI, ADDIU, ADDU/ADD (func 100000), OR (func 100101), LW, SW, BEQ, J.
- Replaces single-cycle decode with an FSM that steps through fetch, decode, execute, memory and writeback.
- Handshakes with instruction and data memories, which may stall.
- Drives the existing PC, instruction register, register file, extender, ALU and writeback muxes using the team's standard control encodings.

Parameters:
- CNT_W, 32, width of retired-instruction counter
- STATE_W, 3, width of state debug output

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rstN  in  1  asynchronous active-low reset
- opcode  in  6  instruction register bits [31:26]
- rFunc  in  6  instruction register bits [5:0]
- zeroRes  in  1  ALU result == 0
- imemReady  in  1  instruction memory has valid data this cycle
- dmemReady  in  1  data memory has completed the access this cycle
- imemReq  out  1  instruction fetch request
- irWriteEn  out  1  load instruction register
- dmemReq  out  1  data memory request
- memWriteEn  out  1  data memory write (valid with dmemReq)
- pcWriteEn  out  1  update PC using jumpOp
- jumpOp  out  2  00 default, 01 PC+4, 10 J, 11 BEQ target
- extendOp  out  2  00 default, 01 left16, 10 signed imm32, 11 unsigned off32
- regWriteEn  out  1  register file write
- aluOp  out  2  00 default, 01 plus, 10 minus, 11 or
- writeReg  out  1  0 rt, 1 rd
- srcAlu  out  1  0 register, 1 extended immediate
- srcReg  out  2  00 default, 01 imm, 10 ALU, 11 mem
- illegalInstr  out  1  one-cycle pulse on unsupported opcode/func
- retired  out  CNT_W  count of completed instructions
- state  out  STATE_W  current FSM state (debug)

Behaviour:
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Codes 5-7 are unreachable and transition to FETCH.
- Reset (rstN low, asynchronous):
  - state=FETCH, retired=0, instruction class register cleared.
  - All outputs forced to 0 while rstN is low, including imemReq.
  - Reset mid-instruction abandons it; no pcWriteEn or regWriteEn is issued.
- Outputs are combinational from the registered state and the registered instruction class.
- Datapath selects (extendOp, aluOp, srcAlu, writeReg, srcReg) hold their instruction values from EXEC through the end of the instruction. They are 0 in FETCH and DECODE.
- FETCH:
  - imemReq=1.
  - Stay while imemReady=0.
  - When imemReady=1: irWriteEn=1 for that cycle, then go to DECODE.
- DECODE:
  - Latch the class from opcode/rFunc. Opcode/rFunc are ignored in all other states.
  - Illegal opcode, or R-type with an unsupported func: illegalInstr=1, pcWriteEn=1, jumpOp=01, go to FETCH. retired does not increment.
  - Otherwise go to EXEC.
- EXEC:
  - ADDU/OR: aluOp 01/11, srcAlu=0, go to WB.
  - ADDIU: extendOp=10, srcAlu=1, aluOp=01, go to WB.
  - LUI: extendOp=01, go to WB.
  - LW/SW: extendOp=11, srcAlu=1, aluOp=01, go to MEM.
  - BEQ: aluOp=10, pcWriteEn=1, jumpOp = zeroRes ? 11 : 01, retired+1, go to FETCH.
  - J: pcWriteEn=1, jumpOp=10, retired+1, go to FETCH.
- MEM:
  - dmemReq=1; memWriteEn=1 for SW only.
  - Stay while dmemReady=0; all signals are held stable during the stall.
  - On dmemReady=1: LW goes to WB; SW asserts pcWriteEn=1, jumpOp=01, retired+1, and goes to FETCH.
- WB (one cycle), then FETCH:
  - regWriteEn=1, pcWriteEn=1, jumpOp=01, retired+1.
  - writeReg=1 for ADDU/OR, else 0.
  - srcReg: LUI 01, ADDIU/ADDU/OR 10, LW 11.
- Cycle counts with zero memory wait: ALU ops and LUI take 4 cycles; LW 5; SW 4; BEQ and J 3. Each wait cycle adds 1.
- pcWriteEn asserts exactly once per instruction. regWriteEn asserts at most once.
- retired wraps modulo 2^CNT_W.
- imemReady while not in FETCH and dmemReady while not in MEM are ignored.

Test Plan:
- Reset held low, then released with imemReady=1 and opcode=001001 (ADDIU) -> states 0,1,2,4,0. WB cycle shows regWriteEn=1, srcReg=10, writeReg=0, pcWriteEn=1, jumpOp=01. retired=1.
- LW with dmemReady low for 3 cycles in MEM -> dmemReq=1 and memWriteEn=0 for 4 cycles. Then WB with srcReg=11. Total 8 cycles; single pcWriteEn.
- SW with dmemReady=1 immediately -> memWriteEn=1 one cycle with pcWriteEn=1, jumpOp=01. regWriteEn never asserted.
- BEQ with zeroRes=1, then BEQ with zeroRes=0 -> EXEC jumpOp 11 then 01, each with pcWriteEn=1. 3 cycles each. retired +2.
- opcode=000000, rFunc=101010 -> illegalInstr pulse in DECODE, pcWriteEn=1, jumpOp=01, retired unchanged. Next state FETCH.
- rstN pulsed low during MEM stall of an LW -> outputs 0 immediately, state=0, retired=0. No regWriteEn afterwards for the aborted LW.
